// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multi-port integer register file.
package regfile_pkg;

    localparam int unsigned REGADDR_W = 5;

    typedef enum logic [1:0] {
        RST,
        INIT,
        RUN
    } rfstate_t;

    // Architectural register count: 16 for the embedded profile, 32 otherwise.
    function automatic int unsigned numregs(input logic e_supported);
        return e_supported ? 32'd16 : 32'd32;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write port bundle of the register file; the file itself is the slave.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 1
);

    logic [NWRITE-1:0]           we;
    logic [NWRITE*REGADDR_W-1:0] wa;
    logic [NWRITE*XLEN-1:0]      wd;
    logic [NREAD*REGADDR_W-1:0]  ra;
    logic [NREAD*XLEN-1:0]       rd;
    logic                        ready;

    modport master (output we, wa, wd, ra, input rd, ready);
    modport slave  (input we, wa, wd, ra, output rd, ready);

endinterface

// File: rtl/regfile_init.sv
// Post-reset zeroing sweep: walks x1..x(NUMREGS-1) once, then raises ready.
module regfile_init
    import regfile_pkg::*;
#(
    parameter int unsigned NUMREGS = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 sweep_we_o,
    output logic [REGADDR_W-1:0] sweep_idx_o,
    output logic                 ready_o
);

    localparam logic [REGADDR_W-1:0] LAST_IDX = REGADDR_W'(NUMREGS - 1);

    rfstate_t             state_q, state_d;
    logic [REGADDR_W-1:0] idx_q, idx_d;
    logic                 sweep_we_q, sweep_we_d;
    logic                 ready_q, ready_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RST;
            idx_q      <= REGADDR_W'(1);
            sweep_we_q <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            sweep_we_q <= sweep_we_d;
            ready_q    <= ready_d;
        end
    end

    // Enable/ready are registered from the next state so they line up with state_q.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        sweep_we_d = 1'b0;
        ready_d    = 1'b0;
        case (state_q)
            RST:  state_d = INIT;
            INIT: begin
                idx_d = idx_q + REGADDR_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = RST;
        endcase
        sweep_we_d = (state_d == INIT);
        ready_d    = (state_d == RUN);
    end

    assign sweep_we_o  = sweep_we_q;
    assign sweep_idx_o = idx_q;
    assign ready_o     = ready_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with same-cycle write-to-read bypass.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned E_SUPPORTED = 0,
    parameter int unsigned NREAD       = 2,
    parameter int unsigned NWRITE      = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    regfile_mp_if.slave  bus
);

    localparam int unsigned NUMREGS = numregs(E_SUPPORTED != 0);

    logic                 sweep_we;
    logic [REGADDR_W-1:0] sweep_idx;
    logic                 ready;

    regfile_init #(.NUMREGS(NUMREGS)) u_init (
        .clk        (clk),
        .reset_n    (reset_n),
        .sweep_we_o (sweep_we),
        .sweep_idx_o(sweep_idx),
        .ready_o    (ready)
    );

    assign bus.ready = ready;

    // A write port is live only for x1..x(NUMREGS-1); x0 and absent registers drop.
    logic [NWRITE-1:0] wr_ok_c;
    always_comb begin
        wr_ok_c = '0;
        for (int unsigned k = 0; k < NWRITE; k++) begin
            wr_ok_c[k] = bus.we[k]
                      && (bus.wa[k*REGADDR_W +: REGADDR_W] != '0)
                      && (32'(bus.wa[k*REGADDR_W +: REGADDR_W]) < NUMREGS);
        end
    end

    logic [XLEN-1:0]      regs_q   [1:NUMREGS-1];
    logic [NUMREGS-1:1]   reg_we_c;
    logic [XLEN-1:0]      reg_wd_c [1:NUMREGS-1];

    // Sweep owns the write path until ready; later ports override earlier ones.
    always_comb begin
        reg_we_c = '0;
        for (int unsigned r = 1; r < NUMREGS; r++) begin
            reg_wd_c[r] = '0;
            if (sweep_we && (sweep_idx == REGADDR_W'(r))) begin
                reg_we_c[r] = 1'b1;
            end else if (ready) begin
                for (int unsigned k = 0; k < NWRITE; k++) begin
                    if (wr_ok_c[k] && (bus.wa[k*REGADDR_W +: REGADDR_W] == REGADDR_W'(r))) begin
                        reg_we_c[r] = 1'b1;
                        reg_wd_c[r] = bus.wd[k*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned r = 1; r < NUMREGS; r++) begin
            if (reg_we_c[r]) begin
                regs_q[r] <= reg_wd_c[r];
            end
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [REGADDR_W-1:0] ra;
        logic [XLEN-1:0]      rd_c;

        assign ra = bus.ra[p*REGADDR_W +: REGADDR_W];

        // Storage, then bypass (highest port wins), then gate by ready.
        always_comb begin
            rd_c = '0;
            for (int unsigned r = 1; r < NUMREGS; r++) begin
                if (ra == REGADDR_W'(r)) begin
                    rd_c = regs_q[r];
                end
            end
            for (int unsigned k = 0; k < NWRITE; k++) begin
                if (wr_ok_c[k] && (bus.wa[k*REGADDR_W +: REGADDR_W] == ra)) begin
                    rd_c = bus.wd[k*XLEN +: XLEN];
                end
            end
            if (!ready) begin
                rd_c = '0;
            end
        end

        assign bus.rd[p*XLEN +: XLEN] = rd_c;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: I-mode 2R/2W file plus an E-mode 1R/1W file on a shared clock and reset.
module tb_regfile_mp;

    localparam int unsigned XLEN = 64;

    logic clk;
    logic reset_n;
    int   vectors     = 0;
    int   miscompares = 0;

    regfile_mp_if #(.XLEN(XLEN), .NREAD(2), .NWRITE(2)) bi ();
    regfile_mp_if #(.XLEN(XLEN), .NREAD(1), .NWRITE(1)) be ();

    regfile_mp #(.XLEN(XLEN), .E_SUPPORTED(0), .NREAD(2), .NWRITE(2)) dut_i (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bi.slave)
    );

    regfile_mp #(.XLEN(XLEN), .E_SUPPORTED(1), .NREAD(1), .NWRITE(1)) dut_e (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (be.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_and_check(input string phase);
        for (int e = 1; e <= 32; e++) begin
            tick();
            if (e < 32) begin
                check($sformatf("%s_ready_i@%0d", phase, e), 64'(bi.ready), 64'd0);
                check($sformatf("%s_rd0@%0d", phase, e), bi.rd[63:0], 64'd0);
                check($sformatf("%s_rd1@%0d", phase, e), bi.rd[127:64], 64'd0);
            end else begin
                check($sformatf("%s_ready_i@32", phase), 64'(bi.ready), 64'd1);
            end
            if (e == 15) check($sformatf("%s_ready_e@15", phase), 64'(be.ready), 64'd0);
            if (e == 16) check($sformatf("%s_ready_e@16", phase), 64'(be.ready), 64'd1);
        end
    endtask

    initial begin
        reset_n = 1'b1;
        bi.we = '0; bi.wa = '0; bi.wd = '0; bi.ra = {5'd2, 5'd5};
        be.we = '0; be.wa = '0; be.wd = '0; be.ra = 5'd4;
        #1 reset_n = 1'b0;
        repeat (3) tick();

        check("rst_ready_i", 64'(bi.ready), 64'd0);
        check("rst_ready_e", 64'(be.ready), 64'd0);
        check("rst_rd0", bi.rd[63:0], 64'd0);

        // Release reset with a write to x2 held throughout the sweep.
        reset_n = 1'b1;
        bi.we = 2'b01; bi.wa = {5'd0, 5'd2}; bi.wd = {64'd0, 64'h77};
        sweep_and_check("sweep1");
        bi.we = '0;
        #1;
        check("init_write_ignored_x2", bi.rd[127:64], 64'd0);
        check("swept_x5", bi.rd[63:0], 64'd0);

        // E mode: x20 does not exist and must not alias onto x4.
        be.we = 1'b1; be.wa = 5'd4; be.wd = 64'h44;
        tick();
        be.wa = 5'd20; be.wd = 64'h66; be.ra = 5'd20;
        #1;
        check("e_bypass_x20", be.rd, 64'd0);
        tick();
        be.we = 1'b0;
        #1;
        check("e_stored_x20", be.rd, 64'd0);
        be.ra = 5'd4;
        #1;
        check("e_x4_intact", be.rd, 64'h44);

        // Same-cycle bypass then storage.
        bi.we = 2'b01; bi.wa = {5'd0, 5'd7}; bi.wd = {64'd0, 64'hDEAD_BEEF}; bi.ra = {5'd2, 5'd7};
        #1;
        check("bypass_x7", bi.rd[63:0], 64'hDEAD_BEEF);
        tick();
        bi.we = '0;
        #1;
        check("stored_x7", bi.rd[63:0], 64'hDEAD_BEEF);

        // Both ports to x3: port 1 wins in bypass and storage.
        bi.we = 2'b11; bi.wa = {5'd3, 5'd3}; bi.wd = {64'h22, 64'h11}; bi.ra = {5'd7, 5'd3};
        #1;
        check("conflict_bypass_x3", bi.rd[63:0], 64'h22);
        check("port1_x7", bi.rd[127:64], 64'hDEAD_BEEF);
        tick();
        bi.we = '0;
        #1;
        check("conflict_stored_x3", bi.rd[63:0], 64'h22);

        // x0 is hardwired zero.
        bi.we = 2'b01; bi.wa = {5'd0, 5'd0}; bi.wd = {64'd0, 64'h55}; bi.ra = {5'd3, 5'd0};
        #1;
        check("x0_bypass", bi.rd[63:0], 64'd0);
        tick();
        bi.we = '0;
        #1;
        check("x0_stored", bi.rd[63:0], 64'd0);
        check("x3_after_x0", bi.rd[127:64], 64'h22);

        // Mid-RUN reset pulse clears everything through a fresh sweep.
        bi.we = 2'b01; bi.wa = {5'd0, 5'd9}; bi.wd = {64'd0, 64'hAB}; bi.ra = {5'd7, 5'd9};
        tick();
        bi.we = '0;
        #1;
        check("stored_x9", bi.rd[63:0], 64'hAB);
        reset_n = 1'b0;
        #1;
        check("async_ready_drop", 64'(bi.ready), 64'd0);
        check("async_rd_x9", bi.rd[63:0], 64'd0);
        check("async_ready_drop_e", 64'(be.ready), 64'd0);
        tick();
        reset_n = 1'b1;
        sweep_and_check("sweep2");
        #1;
        check("swept_x9", bi.rd[63:0], 64'd0);
        check("swept_x7", bi.rd[127:64], 64'd0);
        #1;
        check("swept_x4_e", be.rd, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
